// File: rtl/niceplay_burst_gen_pkg.sv
// Shared definitions for the niceplay burst transmitter.
// Contents:
//   state_e  - burst FSM state encoding (IDLE, PULSE, GAP, DONE)
//   CODE_W   - width of the transmitted code
//   COUNT_W  - width of the pulse count / one-hot word (2^CODE_W)
//   GAP_W    - width of the inter-pulse gap counter
package niceplay_burst_gen_pkg;

    localparam int unsigned CODE_W  = 3;
    localparam int unsigned COUNT_W = 1 << CODE_W;
    localparam int unsigned GAP_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/niceplay_burst_gen_onehot_enc3.sv
// 3-bit code to 8-bit one-hot encoder; the inverse of the receiver's decoder.
// Ports:
//   code_i   [CODE_W-1:0]   code to encode
//   onehot_o [COUNT_W-1:0]  1 << code_i
module onehot_enc3
    import niceplay_burst_gen_pkg::*;
(
    input  logic [CODE_W-1:0]  code_i,
    output logic [COUNT_W-1:0] onehot_o
);

    assign onehot_o = COUNT_W'(1) << code_i;

endmodule

// File: rtl/niceplay_burst_gen.sv
// Transmitter for the niceplay/contents pulse-count link. A code accepted on
// the valid/ready handshake produces exactly 2^code single-cycle niceplay
// pulses, optionally separated by GAP idle cycles, followed by a one-cycle
// done pulse.
// Parameters:
//   GAP         idle cycles between consecutive pulses (0..15)
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   code_valid  requester presents a code
//   code_ready  block can accept a code (IDLE only)
//   code        code to transmit, sampled on handshake
//   niceplay    registered pulse output to the receiver
//   onehot      1 << latched code, held until the next accept
//   busy        high from the cycle after accept through DONE
//   done        single-cycle pulse after the last niceplay pulse
//
// state    | meaning
// ---------+----------------------------------------------
// ST_IDLE  | waiting for a code, code_ready high
// ST_PULSE | niceplay high this cycle, remaining decrements
// ST_GAP   | idle spacing between pulses
// ST_DONE  | done pulse, then back to idle
module niceplay_burst_gen
    import niceplay_burst_gen_pkg::*;
#(
    parameter int unsigned GAP = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               code_valid,
    output logic               code_ready,
    input  logic [CODE_W-1:0]  code,
    output logic               niceplay,
    output logic [COUNT_W-1:0] onehot,
    output logic               busy,
    output logic               done
);

    // Gap counter reloads with GAP-1 so that GAP cycles are spent in ST_GAP.
    localparam logic [GAP_W-1:0] GAP_RELOAD = (GAP == 0) ? '0 : GAP_W'(GAP - 1);

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [COUNT_W-1:0] onehot_q, onehot_d;
    logic               niceplay_q;
    logic               busy_q;
    logic               done_q;
    logic               code_ready_q;
    logic [COUNT_W-1:0] enc_word;
    logic               accept;

    onehot_enc3 u_enc (
        .code_i   (code),
        .onehot_o (enc_word)
    );

    // code_ready_q is high exactly in ST_IDLE, so the handshake needs no
    // separate state qualifier.
    assign accept = code_valid && code_ready_q;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        gap_cnt_d   = gap_cnt_q;
        onehot_d    = onehot_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    onehot_d    = enc_word;
                    remaining_d = enc_word;
                    state_d     = ST_PULSE;
                end
            end
            ST_PULSE: begin
                remaining_d = remaining_q - COUNT_W'(1);
                if (remaining_d == '0) begin
                    state_d = ST_DONE;
                end else if (GAP == 0) begin
                    state_d = ST_PULSE;
                end else begin
                    gap_cnt_d = GAP_RELOAD;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_PULSE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe without any input-to-output combinational path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            gap_cnt_q    <= '0;
            onehot_q     <= '0;
            niceplay_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            code_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            gap_cnt_q    <= gap_cnt_d;
            onehot_q     <= onehot_d;
            niceplay_q   <= (state_d == ST_PULSE);
            busy_q       <= (state_d != ST_IDLE);
            done_q       <= (state_d == ST_DONE);
            code_ready_q <= (state_d == ST_IDLE);
        end
    end

    assign code_ready = code_ready_q;
    assign niceplay   = niceplay_q;
    assign onehot     = onehot_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_niceplay_burst_gen.sv
// Directed bench for niceplay_burst_gen: one instance with GAP=0, one with
// GAP=2, plus a small pulse-counting receiver model on the GAP=0 instance.
module tb_niceplay_burst_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       v0, v2;
    logic [2:0] c0, c2;
    logic       rdy0, rdy2, np0, np2, busy0, busy2, dn0, dn2;
    logic [7:0] oh0, oh2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    niceplay_burst_gen #(.GAP(0)) dut0 (
        .clk(clk), .rst(rst), .code_valid(v0), .code_ready(rdy0), .code(c0),
        .niceplay(np0), .onehot(oh0), .busy(busy0), .done(dn0)
    );

    niceplay_burst_gen #(.GAP(2)) dut2 (
        .clk(clk), .rst(rst), .code_valid(v2), .code_ready(rdy2), .code(c2),
        .niceplay(np2), .onehot(oh2), .busy(busy2), .done(dn2)
    );

    // Receiver model: cumulative pulse counter with one-hot decoder.
    logic       rx_rst;
    logic [7:0] rx_count;

    always @(posedge clk or posedge rx_rst) begin
        if (rx_rst) rx_count <= 8'h00;
        else if (np0) rx_count <= rx_count + 8'h01;
    end

    function automatic logic [2:0] rx_contents(input logic [7:0] cnt);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (cnt[i]) r = 3'(i);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Present a code, check ready, let the accepting edge pass.
    // Returns at cycle 1 after the accept, 1 ns past the edge.
    task automatic start(input bit sel, input logic [2:0] c, input bit keep, input string tag);
        if (!sel) begin
            v0 = 1'b1; c0 = c;
            chk({tag, "_ready"}, 256'(rdy0), 256'(1));
        end else begin
            v2 = 1'b1; c2 = c;
            chk({tag, "_ready"}, 256'(rdy2), 256'(1));
        end
        @(posedge clk); #1;
        if (!keep) begin
            v0 = 1'b0; v2 = 1'b0;
        end
    endtask

    // Sample cycles 1..n; bit i of pm/dm is niceplay/done in cycle i.
    task automatic watch(input bit sel, input int n, output logic [255:0] pm,
                         output logic [255:0] dm, output int npulse);
        pm = '0; dm = '0; npulse = 0;
        for (int i = 1; i <= n; i++) begin
            if (i > 1) begin
                @(posedge clk); #1;
            end
            if (sel ? np2 : np0) begin
                pm[i] = 1'b1;
                npulse++;
            end
            if (sel ? dn2 : dn0) dm[i] = 1'b1;
        end
    endtask

    logic [255:0] pm, dm, epm, edm;
    int           np, cnt;
    logic         rej_bad, idle_seen;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rx_rst = 1'b1;
        v0 = 1'b0; v2 = 1'b0; c0 = 3'd0; c2 = 3'd0;
        #22;
        rst = 1'b0; rx_rst = 1'b0;
        @(posedge clk); #1;

        // Reset state
        chk("rst_ready", 256'(rdy0), 256'(1));
        chk("rst_niceplay", 256'(np0), 256'(0));
        chk("rst_busy", 256'(busy0), 256'(0));
        chk("rst_done", 256'(dn0), 256'(0));
        chk("rst_onehot", 256'(oh0), 256'(8'h00));

        // GAP=0, code=0
        rx_rst = 1'b1; #1; rx_rst = 1'b0;
        start(1'b0, 3'd0, 1'b0, "c0");
        chk("c0_busy_c1", 256'(busy0), 256'(1));
        watch(1'b0, 3, pm, dm, np);
        epm = '0; epm[1] = 1'b1;
        edm = '0; edm[2] = 1'b1;
        chk("c0_pulses", pm, epm);
        chk("c0_done", dm, edm);
        chk("c0_ready_back", 256'(rdy0), 256'(1));
        chk("c0_busy_idle", 256'(busy0), 256'(0));
        chk("c0_onehot", 256'(oh0), 256'(8'h01));
        chk("c0_rx_count", 256'(rx_count), 256'(8'h01));
        chk("c0_rx_contents", 256'(rx_contents(rx_count)), 256'(3'b000));

        // GAP=0, code=7
        rx_rst = 1'b1; #1; rx_rst = 1'b0;
        start(1'b0, 3'd7, 1'b0, "c7");
        watch(1'b0, 130, pm, dm, np);
        epm = '0; for (int i = 1; i <= 128; i++) epm[i] = 1'b1;
        edm = '0; edm[129] = 1'b1;
        chk("c7_pulses", pm, epm);
        chk("c7_npulse", 256'(np), 256'(128));
        chk("c7_done", dm, edm);
        chk("c7_ready_back", 256'(rdy0), 256'(1));
        chk("c7_onehot", 256'(oh0), 256'(8'h80));
        chk("c7_rx_count", 256'(rx_count), 256'(8'h80));
        chk("c7_rx_contents", 256'(rx_contents(rx_count)), 256'(3'b111));

        // GAP=2, code=2
        start(1'b1, 3'd2, 1'b0, "g2");
        watch(1'b1, 12, pm, dm, np);
        epm = '0; epm[1] = 1'b1; epm[4] = 1'b1; epm[7] = 1'b1; epm[10] = 1'b1;
        edm = '0; edm[11] = 1'b1;
        chk("g2_pulses", pm, epm);
        chk("g2_done", dm, edm);
        chk("g2_ready_back", 256'(rdy2), 256'(1));
        chk("g2_onehot", 256'(oh2), 256'(8'h04));

        // Busy rejection: code=5 offered during a code=3 burst
        start(1'b0, 3'd3, 1'b0, "rej");
        pm = '0; dm = '0; np = 0; rej_bad = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (i > 1) begin
                @(posedge clk); #1;
            end
            if (i == 2) begin
                v0 = 1'b1; c0 = 3'd5;
            end
            if (i >= 2 && i <= 6 && rdy0) rej_bad = 1'b1;
            if (np0) begin
                pm[i] = 1'b1;
                np++;
            end
            if (dn0) dm[i] = 1'b1;
            if (i == 6) v0 = 1'b0;
        end
        epm = '0; for (int i = 1; i <= 8; i++) epm[i] = 1'b1;
        edm = '0; edm[9] = 1'b1;
        chk("rej_ready_low", 256'(rej_bad), 256'(0));
        chk("rej_pulses", pm, epm);
        chk("rej_done", dm, edm);
        chk("rej_onehot", 256'(oh0), 256'(8'h08));

        // Reset mid-burst: code=6, reset after pulse 10
        start(1'b0, 3'd6, 1'b0, "mid");
        cnt = 0;
        for (int i = 1; i <= 20 && cnt < 10; i++) begin
            if (i > 1) begin
                @(posedge clk); #1;
            end
            if (np0) cnt++;
        end
        chk("mid_reach10", 256'(cnt), 256'(10));
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_niceplay", 256'(np0), 256'(0));
        chk("mid_rst_busy", 256'(busy0), 256'(0));
        chk("mid_rst_done", 256'(dn0), 256'(0));
        chk("mid_rst_onehot", 256'(oh0), 256'(8'h00));
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_ready_after", 256'(rdy0), 256'(1));
        chk("mid_no_resume", 256'(np0), 256'(0));
        start(1'b0, 3'd1, 1'b0, "mid_c1");
        watch(1'b0, 4, pm, dm, np);
        epm = '0; epm[1] = 1'b1; epm[2] = 1'b1;
        edm = '0; edm[3] = 1'b1;
        chk("mid_c1_pulses", pm, epm);
        chk("mid_c1_done", dm, edm);

        // Back-to-back: valid held high, code=1 then code=2
        start(1'b0, 3'd1, 1'b1, "b2b");
        pm = '0; dm = '0; np = 0; idle_seen = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (i > 1) begin
                @(posedge clk); #1;
            end
            if (i == 1) c0 = 3'd2;
            if (np0) begin
                pm[i] = 1'b1;
                np++;
            end
            if (dn0) dm[i] = 1'b1;
            if (i == 4) idle_seen = rdy0;
            if (i == 9) v0 = 1'b0;
        end
        epm = '0; epm[1] = 1'b1; epm[2] = 1'b1;
        for (int i = 5; i <= 8; i++) epm[i] = 1'b1;
        edm = '0; edm[3] = 1'b1; edm[9] = 1'b1;
        chk("b2b_pulses", pm, epm);
        chk("b2b_done", dm, edm);
        chk("b2b_idle_gap", 256'(idle_seen), 256'(1));
        chk("b2b_onehot", 256'(oh0), 256'(8'h04));
        chk("b2b_ready_end", 256'(rdy0), 256'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/niceplay_burst_gen.md
# niceplay_burst_gen

Transmitter side of the niceplay/contents pulse-count link. Accepts a 3-bit code over a valid/ready handshake and emits exactly 2^code single-cycle `niceplay` pulses, so that a freshly reset downstream pulse counter and one-hot decoder end at count = 2^code and `contents` = code. It also presents the matching one-hot word for local checking, and sits between the control logic that selects a code and the counting receiver.

## Interface
- `GAP`, default 0: idle (low) cycles inserted between consecutive `niceplay` pulses; legal range 0..15.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `code_valid`  in  1  requester has a code on `code`.
- `code_ready`  out  1  block can accept a code; handshake fires when `code_valid` and `code_ready` are both high at a rising edge.
- `code`  in  3  code to transmit; sampled only on the handshake.
- `niceplay`  out  1  registered pulse output to the receiver.
- `onehot`  out  8  equals 1 << latched code; held until the next accept.
- `busy`  out  1  high from the cycle after accept through the DONE state.
- `done`  out  1  single-cycle pulse after the last `niceplay` pulse.

## Operation
- States: IDLE, PULSE, GAP, DONE. One-hot or binary encoding is acceptable.
- IDLE: `code_ready`=1 and `busy`=0. On handshake:
  - `onehot` <= 1<<code.
  - `remaining` <= 1<<code (8-bit, range 1..128).
  - Go to PULSE.
- PULSE: `niceplay`=1 for this cycle, and `remaining` decrements.
  - If the decremented value is 0, go to DONE.
  - Else if GAP=0, stay in PULSE.
  - Else load the gap counter with GAP-1 and go to GAP.
- GAP: `niceplay`=0. When the gap counter reaches 0, go to PULSE; otherwise decrement it.
- DONE: `done`=1, `niceplay`=0, `code_ready`=0, `busy`=1. Unconditionally go to IDLE.
- Outside IDLE, `code_ready`=0. `code_valid` is ignored and `code` is not sampled; there is no queuing.
- Arithmetic:
  - `remaining` is 8 bits and never underflows, because the state exits at 0.
  - The gap counter is 4 bits.
  - 1<<7 = 8'h80 fits exactly.
- All outputs come straight from registers or are decoded from state only; there are no combinational paths from inputs to outputs.
- Reset, asynchronous at any time including mid-burst:
  - State goes to IDLE.
  - `niceplay`=0, `done`=0, `busy`=0, `onehot`=8'h00, `remaining`=0, gap counter = 0.
  - `code_ready`=1 once `rst` deasserts.
  - A burst cut short by reset is not resumed.
- The receiver's count is cumulative. One-hot correspondence holds only if the receiver is reset before each burst; this is the system's responsibility, not this block's.

## Timing
- Accept at edge E0: `niceplay` is high in cycle 1 after E0.
- With GAP=0, pulses occupy cycles 1..N, where N = 2^code; `done` is high in cycle N+1; `code_ready` returns in cycle N+2.
- With GAP=g, pulse i (i=0..N-1) is in cycle 1+i*(g+1), and `done` is one cycle after the last pulse.
- Total occupancy per code: N + (N-1)*g + 1 cycles. The next accept is possible at the edge ending cycle N+(N-1)*g+2.
- `code_valid` held high continuously produces back-to-back bursts separated by one DONE cycle plus one IDLE cycle.

## Structure
- Shared package: the state enum (IDLE, PULSE, GAP, DONE), the code width (3), and the count width (8, = 2^code width).
- Sub-module `onehot_enc3`: 3-bit code to 8-bit one-hot, the inverse of the receiver's decoder. Combinational and instantiated once. Everything else stays in one module.

## Test plan
- GAP=0, code=0: one `niceplay` pulse in cycle 1, `done` in cycle 2, `onehot`=8'h01; a reset receiver ends at count 8'h01 and `contents`=3'b000.
- GAP=0, code=7: exactly 128 contiguous pulses, `done` in cycle 129, `onehot`=8'h80; receiver `contents`=3'b111.
- GAP=2, code=2: pulses in cycles 1, 4, 7, 10 and `done` in cycle 11; no pulse in any other cycle.
- Busy rejection: during a code=3 burst, assert `code_valid` with code=5. Required: `code_ready`=0, exactly 8 pulses, `onehot` stays 8'h08.
- Reset mid-burst: code=6 and `rst` asserted after pulse 10. Required: `niceplay`, `busy`, `done` go low immediately; `onehot`=8'h00; `code_ready`=1 on the first edge after release; a new code=1 then yields exactly 2 pulses.
- Back-to-back: `code_valid` held high with code=1 then code=2. Required: 2 pulses, `done`, one idle cycle, 4 pulses, `done`.
